// File: rtl/ram_arbiter_pkg.sv
// Shared arbiter types: FSM state encodings, requester IDs and byte geometry.
package ram_arbiter_pkg;
    typedef enum logic { ARB_IDLE = 1'b0, ARB_RMW_WR = 1'b1 } arb_state_t;
    typedef enum logic { REQ_I = 1'b0, REQ_D = 1'b1 } req_id_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_BITS  = 8;
endpackage

// File: rtl/ram_arbiter_byte_lane.sv
// Byte-lane extract (zero-extended) and merge for one word; purely combinational.
// Zero latency, no flow control.
module ram_arbiter_byte_lane
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]     word,
    input  logic [1:0]           lane,
    input  logic [BYTE_BITS-1:0] byte_in,
    output logic [WIDTH-1:0]     extracted,
    output logic [WIDTH-1:0]     merged
);
    localparam int OFS_W = $clog2(WIDTH);

    logic [OFS_W-1:0] bit_ofs;
    assign bit_ofs = OFS_W'({lane, 3'b000});

    always_comb begin
        extracted                          = '0;
        extracted[BYTE_BITS-1:0]           = word[bit_ofs +: BYTE_BITS];
        merged                             = word;
        merged[bit_ofs +: BYTE_BITS]       = byte_in;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin I/D arbiter for the single-port data RAM; byte access built with RAM_BYTE_ACCESS_EN.
// Grant is combinational, read data returns 1 cycle later; byte store holds off all grants for 1 RMW cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_rvalid,
    input  logic             d_req,
    input  logic             d_we,
    input  logic             d_byte,
    input  logic [31:0]      d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] ram_d,
    output logic [31:0]      ram_ad,
    output logic             ram_we,
    input  logic [WIDTH-1:0] ram_q
);
    logic [ADDR_WIDTH-1:0] i_idx, d_idx, ad_q;
    req_id_t               last_gnt;
    logic                  idle;

    assign i_idx = i_addr[ADDR_WIDTH+1:2];
    assign d_idx = d_addr[ADDR_WIDTH+1:2];

`ifdef RAM_BYTE_ACCESS_EN
    arb_state_t           state;
    logic [1:0]           lane_q;
    logic                 byte_q;
    logic [BYTE_BITS-1:0] wbyte_q;
    logic [WIDTH-1:0]     lane_ext, lane_merged;
    logic                 unused_addr;

    assign idle        = (state == ARB_IDLE);
    assign unused_addr = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0], d_addr[31:ADDR_WIDTH+2]};

    // One lane unit serves both the load-return extract and the RMW merge; both use the registered lane.
    ram_arbiter_byte_lane #(.WIDTH(WIDTH)) u_byte_lane (
        .word     (ram_q),
        .lane     (lane_q),
        .byte_in  (wbyte_q),
        .extracted(lane_ext),
        .merged   (lane_merged)
    );

    assign d_rdata = !d_rvalid ? '0 : (byte_q ? lane_ext : ram_q);
`else
    logic unused_addr;

    assign idle        = 1'b1;
    assign unused_addr = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0], d_addr[31:ADDR_WIDTH+2],
                           d_addr[1:0], d_byte};
    assign d_rdata     = d_rvalid ? ram_q : '0;
`endif

    assign i_rdata = i_rvalid ? ram_q : '0;

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst && idle) begin
            if (i_req && d_req) begin
                if (last_gnt == REQ_I) d_gnt = 1'b1;
                else                   i_gnt = 1'b1;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    // With no grant the RAM address parks on the last one used, so the RMW write hits the read word.
    always_comb begin
        ram_we = 1'b0;
        ram_d  = '0;
        ram_ad = '0;
        if (!rst) begin
            ram_ad = {{(32-ADDR_WIDTH){1'b0}}, ad_q};
            if (i_gnt) begin
                ram_ad = {{(32-ADDR_WIDTH){1'b0}}, i_idx};
            end else if (d_gnt) begin
                ram_ad = {{(32-ADDR_WIDTH){1'b0}}, d_idx};
                ram_d  = d_wdata;
`ifdef RAM_BYTE_ACCESS_EN
                ram_we = d_we && !d_byte;
            end else if (state == ARB_RMW_WR) begin
                ram_we = 1'b1;
                ram_d  = lane_merged;
`else
                ram_we = d_we;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= REQ_I;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            ad_q     <= '0;
`ifdef RAM_BYTE_ACCESS_EN
            state    <= ARB_IDLE;
            lane_q   <= '0;
            byte_q   <= 1'b0;
            wbyte_q  <= '0;
`endif
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt && !d_we;
            if (i_gnt) begin
                last_gnt <= REQ_I;
                ad_q     <= i_idx;
            end
            if (d_gnt) begin
                last_gnt <= REQ_D;
                ad_q     <= d_idx;
            end
`ifdef RAM_BYTE_ACCESS_EN
            if (d_gnt) begin
                lane_q  <= d_addr[1:0];
                byte_q  <= d_byte;
                wbyte_q <= d_wdata[BYTE_BITS-1:0];
            end
            case (state)
                ARB_IDLE:   if (d_gnt && d_we && d_byte) state <= ARB_RMW_WR;
                ARB_RMW_WR: state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
`endif
        end
    end
endmodule
